updown_mod_counter: RTL

Parametrised modulo-N up/down counter with an integrated programmable prescaler, synchronous load, terminal-count flag and wrap pulse. It generalises the fixed 4-bit free-running synchronous counter in width, modulus, direction and rate. It is the standard event/timebase counter for the sequential-logic library, feeding timers, PWM generators and sequencers.

---
 rtl/updown_counter_pkg.sv | 34 +++
 rtl/tick_divider.sv | 48 ++++
 rtl/updown_mod_counter.sv | 112 +++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Provides default sizing, the load-value clamp and the MODULUS/WIDTH legality rule.
package updown_counter_pkg;

    localparam int default_width      = 8;
    localparam int default_modulus    = 256;
    localparam int default_prescale_w = 4;

    // Helpers operate at a fixed wide width; callers truncate to their own WIDTH.
    localparam int clamp_w = 32;

    function automatic logic [clamp_w-1:0] clamp_val(
        input logic [clamp_w-1:0] value,
        input logic [clamp_w:0]   modulus
    );
        logic [clamp_w:0] wide_s;
        logic [clamp_w:0] top_s;
        wide_s = {1'b0, value};
        top_s  = modulus - (clamp_w + 1)'(1);
        if (wide_s >= modulus) begin
            clamp_val = top_s[clamp_w-1:0];
        end else begin
            clamp_val = value;
        end
    endfunction

    function automatic bit modulus_legal(input int width, input longint modulus);
        bit ok_s;
        ok_s = (width >= 32'sd2) && (width <= 32'sd31) &&
               (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
        return ok_s;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
// clear restarts the count and suppresses the tick on that edge.
module tick_divider
    import updown_counter_pkg::*;
#(
    parameter int PRESCALE_W = default_prescale_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc_r;
    logic                  tick_s;

    // Compare against the live setting so a lowered prescale fires on the next enabled cycle.
    always_comb begin
        tick_s = 1'b0;
        if (en && !clear && (psc_r >= prescale)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescale counter: cleared by load or tick, frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_r <= '0;
        end else if (clear) begin
            psc_r <= '0;
        end else if (en) begin
            if (tick_s) begin
                psc_r <= '0;
            end else begin
                psc_r <= psc_r + PRESCALE_W'(1);
            end
        end else begin
            psc_r <= psc_r;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with prescaler, synchronous clamped load, tc and wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the bounds instead of wrapping (wrap then stays 0).
module updown_mod_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH      = default_width,
    parameter int MODULUS    = default_modulus,
    parameter int PRESCALE_W = default_prescale_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  wrap
);

    if (!modulus_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // Held WIDTH bits wide so MODULUS == 2**WIDTH yields all-ones, not an overflowed compare.
    localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             tick_s;
    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] next_q_s;
    logic             next_wrap_s;

    tick_divider #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_divider (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick_s)
    );

    assign load_clamped_s = WIDTH'(clamp_val(clamp_w'(load_val), (clamp_w + 1)'(MODULUS)));

    // Step result for the direction sampled on this edge.
    always_comb begin
        next_q_s    = q_r;
        next_wrap_s = 1'b0;
        if (up) begin
            if (q_r == max_val) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                next_q_s    = q_r;
                next_wrap_s = 1'b0;
`else
                next_q_s    = '0;
                next_wrap_s = 1'b1;
`endif
            end else begin
                next_q_s    = q_r + WIDTH'(1);
                next_wrap_s = 1'b0;
            end
        end else begin
            if (q_r == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                next_q_s    = q_r;
                next_wrap_s = 1'b0;
`else
                next_q_s    = max_val;
                next_wrap_s = 1'b1;
`endif
            end else begin
                next_q_s    = q_r - WIDTH'(1);
                next_wrap_s = 1'b0;
            end
        end
    end

    // Count register: reset > load > step > hold; wrap only survives a wrapping step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else if (load) begin
            q_r    <= load_clamped_s;
            wrap_r <= 1'b0;
        end else if (tick_s) begin
            q_r    <= next_q_s;
            wrap_r <= next_wrap_s;
        end else begin
            q_r    <= q_r;
            wrap_r <= 1'b0;
        end
    end

    // Terminal count is purely combinational so it tracks a direction change immediately.
    always_comb begin
        tc = 1'b0;
        if (up) begin
            tc = (q_r == max_val);
        end else begin
            tc = (q_r == '0);
        end
    end

    assign q    = q_r;
    assign wrap = wrap_r;

endmodule
